// File: rtl/camera64x64_pkg.sv
// Shared types and default geometry for the 64x64 camera readout sequencer.
package camera64x64_pkg;

  localparam int PIX_W    = 8;
  localparam int CAM_COLS = 64;
  localparam int CAM_ROWS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_STALL,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/camera64x64_sclk_gen.sv
// SCLK register plus half-period down-counter; phase_end_o flags the last cycle of a phase.
module camera64x64_sclk_gen #(
  parameter int SCLK_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic load_i,
  input  logic sclk_set_i,
  output logic sclk_o,
  output logic phase_end_o
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (load_i) begin
      cnt_d  = CW'(SCLK_DIV - 1);
      sclk_d = sclk_set_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o      = sclk_q;
  assign phase_end_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/camera64x64_seq.sv
// Readout sequencer: bursts SCLK per line, captures one pixel per pulse, valid/ready output.
// Optional CAM_SEQ_CONTINUOUS_EN: frames repeat back-to-back after a line gap.
//
// state | meaning
// IDLE  | waiting for start_i
// HIGH  | SCLK high half-period, pixel sampled on last cycle
// LOW   | SCLK low half-period
// STALL | SCLK held low until the pending pixel is accepted
// GAP   | inter-line (or inter-frame) idle
// DONE  | one-cycle frame_done_o pulse
module camera64x64_seq
  import camera64x64_pkg::*;
#(
  parameter int DW       = PIX_W,
  parameter int COLS     = CAM_COLS,
  parameter int ROWS     = CAM_ROWS,
  parameter int SCLK_DIV = 5,
  parameter int LINE_GAP = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  output logic          sclk_o,
  input  logic [DW-1:0] pix_in_i,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic [DW-1:0] pix_data_o,
  output logic [5:0]    pix_x_o,
  output logic [5:0]    pix_y_o,
  output logic          busy_o,
  output logic          frame_done_o
);

  localparam int GW = $clog2(LINE_GAP + 1);

  state_t          state_q, state_d;
  logic [5:0]      col_q, col_d, row_q, row_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            valid_q;
  logic [DW-1:0]   data_q;
  logic [5:0]      x_q, y_q;

  logic sg_en, sg_load, sg_set, phase_end, sample;
  logic accepted, last_col, last_row;

  assign sg_en    = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign accepted = !valid_q || pix_ready_i;
  assign last_col = (col_q == 6'(COLS - 1));
  assign last_row = (row_q == 6'(ROWS - 1));

  camera64x64_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (sg_en),
    .load_i      (sg_load),
    .sclk_set_i  (sg_set),
    .sclk_o      (sclk_o),
    .phase_end_o (phase_end)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    gap_d   = gap_q;
    sg_load = 1'b0;
    sg_set  = 1'b0;
    sample  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_HIGH;
          sg_load = 1'b1;
          sg_set  = 1'b1;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          state_d = ST_LOW;
          sg_load = 1'b1;
          sample  = 1'b1;
        end
      end
      ST_LOW, ST_STALL: begin
        // STALL re-evaluates every cycle; LOW only at the end of its half-period
        if ((state_q == ST_STALL) || phase_end) begin
          if (!accepted) begin
            state_d = ST_STALL;
          end else if (!last_col) begin
            state_d = ST_HIGH;
            sg_load = 1'b1;
            sg_set  = 1'b1;
            col_d   = col_q + 6'd1;
          end else if (!last_row) begin
            state_d = ST_GAP;
            gap_d   = GW'(LINE_GAP - 1);
            col_d   = '0;
            row_d   = row_q + 6'd1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_HIGH;
          sg_load = 1'b1;
          sg_set  = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_DONE: begin
`ifdef CAM_SEQ_CONTINUOUS_EN
        state_d = ST_GAP;
        gap_d   = GW'(LINE_GAP - 1);
        col_d   = '0;
        row_d   = '0;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
    end
  end

  // Output pixel register; coordinates are captured together with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (sample) begin
      valid_q <= 1'b1;
      data_q  <= pix_in_i;
      x_q     <= col_q;
      y_q     <= row_q;
    end else if (valid_q && pix_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign pix_valid_o  = valid_q;
  assign pix_data_o   = data_q;
  assign pix_x_o      = x_q;
  assign pix_y_o      = y_q;
  assign frame_done_o = (state_q == ST_DONE);
`ifdef CAM_SEQ_CONTINUOUS_EN
  assign busy_o = (state_q != ST_IDLE);
`else
  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
`endif

endmodule

// File: tb/tb_camera64x64_seq.sv
// Scoreboard bench for camera64x64_seq with a camera model and randomized backpressure.
module tb_camera64x64_seq;

  localparam int DW = 8, COLS = 64, ROWS = 64, SDIV = 2, GAP = 20;
  localparam int NPIX = COLS * ROWS;
  localparam int FRAME_BUDGET = 30000;
`ifdef CAM_SEQ_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, pix_ready_i = 1'b0;
  logic [DW-1:0] pix_in_i = '0;
  logic          sclk_o, pix_valid_o, busy_o, frame_done_o;
  logic [DW-1:0] pix_data_o;
  logic [5:0]    pix_x_o, pix_y_o;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  camera64x64_seq #(.DW(DW), .COLS(COLS), .ROWS(ROWS), .SCLK_DIV(SDIV), .LINE_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .sclk_o(sclk_o), .pix_in_i(pix_in_i),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_data_o(pix_data_o),
    .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  typedef struct packed {logic [5:0] x; logic [5:0] y; logic [DW-1:0] d;} pix_t;
  pix_t        exp_q[$];
  int unsigned seed = 0;

  function automatic logic [DW-1:0] pat(int r, int c);
    return DW'(r * 37 + c * 11 + int'(seed & 32'hFF));
  endfunction

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Camera model: each SCLK rise presents the next raster pixel; garbage while SCLK is low
  int   cam_r = 0, cam_c = 0;
  logic cam_sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cam_r = 0; cam_c = 0; cam_sclk_prev = 1'b0;
      pix_in_i = DW'($urandom);
    end else begin
      if (sclk_o && !cam_sclk_prev) begin
        pix_in_i = pat(cam_r, cam_c);
        cam_c++;
        if (cam_c == COLS) begin cam_c = 0; cam_r = (cam_r + 1) % ROWS; end
      end else if (!sclk_o) begin
        pix_in_i = DW'($urandom);
      end
      cam_sclk_prev = sclk_o;
    end
  end

  // Sink: always ready, random ready, plus one forced 37-cycle stall at pixel x=5,y=3
  bit rnd_ready = 0, stall_req = 0, stall_used = 0;
  int force_low = 0;
  always @(posedge clk) begin
    #1;
    if (stall_req && !stall_used && pix_valid_o && pix_x_o == 6'd5 && pix_y_o == 6'd3) begin
      force_low  = 37;
      stall_used = 1;
    end
    if (force_low > 0) begin
      pix_ready_i = 1'b0;
      force_low--;
    end else if (rnd_ready) pix_ready_i = ($urandom_range(0, 9) < 7);
    else pix_ready_i = 1'b1;
  end

  // Monitor: scoreboard pops, hold stability, SCLK timing, frame accounting
  bit      period_chk = 0;
  int      acc_cnt = 0, acc_last = 0, done_cnt = 0, rise_n = 0;
  longint  cyc = 0, start_cyc = 0;
  bit      start_seen = 0, hold_prev = 0;
  logic    sclk_m = 1'b0;
  logic [19:0] hold_val = '0;
  always @(negedge clk) begin
    pix_t e;
    cyc++;
    if (!rst_n) begin
      hold_prev = 0; sclk_m = 1'b0; rise_n = 0; start_seen = 0;
    end else begin
      if (start_i && !busy_o && !frame_done_o) begin
        start_seen = 1; start_cyc = cyc; rise_n = 0; acc_last = acc_cnt;
      end
      if (hold_prev) begin
        chk("hold_valid", pix_valid_o, 1);
        chk("hold_pixel", {pix_x_o, pix_y_o, pix_data_o}, hold_val);
      end
      if (force_low > 0 && pix_valid_o) chk("stall_sclk_low", sclk_o, 0);
      if (pix_valid_o && pix_ready_i) begin
        chk("sb_nonempty", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pix_x", pix_x_o, e.x);
          chk("pix_y", pix_y_o, e.y);
          chk("pix_data", pix_data_o, e.d);
        end
        acc_cnt++;
      end
      hold_prev = pix_valid_o && !pix_ready_i;
      hold_val  = {pix_x_o, pix_y_o, pix_data_o};
      if (sclk_o && !sclk_m) begin
        if (rise_n == 0 && start_seen) begin
          chk("first_sclk_latency", cyc - start_cyc, 1);
          start_seen = 0;
        end
        if (rise_n > 0 && period_chk)
          chk("sclk_rise_interval", cyc - start_cyc,
              (rise_n % COLS == 0) ? 2 * SDIV + GAP : 2 * SDIV);
        start_cyc = cyc;
        rise_n++;
      end
      sclk_m = sclk_o;
      if (frame_done_o) begin
        done_cnt++;
        chk("busy_at_done", busy_o, CONT);
        chk("pixels_per_frame", acc_cnt - acc_last, NPIX);
        chk("sclk_pulses_per_frame", rise_n, NPIX);
        acc_last = acc_cnt;
        rise_n = 0;
      end
    end
  end

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back('{x: 6'(c), y: 6'(r), d: pat(r, c)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_dones(int n, int budget);
    int d0 = done_cnt;
    int k  = 0;
    while ((done_cnt - d0) < n && k < budget) begin @(posedge clk); k++; end
    chk("frame_done_count", done_cnt - d0, n);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_sclk"}, sclk_o, 0);
    chk({tag, "_valid"}, pix_valid_o, 0);
    chk({tag, "_data"}, pix_data_o, 0);
    chk({tag, "_x"}, pix_x_o, 0);
    chk({tag, "_y"}, pix_y_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, frame_done_o, 0);
  endtask

  initial begin
    int d0, k;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
`ifdef CAM_SEQ_CONTINUOUS_EN
    period_chk = 1;
    seed = $urandom;
    push_frame(); push_frame(); push_frame();
    pulse_start();
    repeat (50) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_dones(3, 3 * FRAME_BUDGET);
    #1 chk("cont_busy_after", busy_o, 1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk_reset_outputs("cont_rst");
    exp_q.delete();
`else
    // Frame 1: sink always ready, SCLK timing checked
    period_chk = 1;
    seed = $urandom;
    push_frame();
    pulse_start();
    wait_dones(1, FRAME_BUDGET);
    repeat (30) @(posedge clk);
    #1 chk("f1_busy_after", busy_o, 0);
    chk("f1_sb_empty", exp_q.size(), 0);
    period_chk = 0;

    // Frame 2: random backpressure, forced stall, START while busy
    rnd_ready = 1; stall_req = 1;
    seed = $urandom;
    push_frame();
    pulse_start();
    repeat (500) @(posedge clk);
    #1 chk("f2_busy_mid", busy_o, 1);
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    d0 = done_cnt;
    wait_dones(1, FRAME_BUDGET);
    repeat (2 * NPIX / 8) @(posedge clk);
    chk("f2_no_extra_frame", done_cnt - d0, 1);
    chk("f2_sb_empty", exp_q.size(), 0);
    chk("f2_stall_hit", stall_used, 1);
    rnd_ready = 0;

    // Frame 3: reset aborts at row 10 col 20
    seed = $urandom;
    push_frame();
    pulse_start();
    d0 = done_cnt;
    k = 0;
    while (!(pix_valid_o && pix_x_o == 6'd20 && pix_y_o == 6'd10) && k < FRAME_BUDGET) begin
      @(negedge clk); k++;
    end
    chk("f3_reached_10_20", int'(pix_valid_o && pix_x_o == 6'd20 && pix_y_o == 6'd10), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midframe_rst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("f3_no_partial_done", done_cnt - d0, 0);

    // Frame 4: restarts from (0,0)
    period_chk = 1;
    seed = $urandom;
    push_frame();
    pulse_start();
    wait_dones(1, FRAME_BUDGET);
    repeat (10) @(posedge clk);
    #1 chk("f4_busy_after", busy_o, 0);
    chk("f4_sb_empty", exp_q.size(), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
